// File: rtl/execution_sequencer_if.sv
// Execution sequencer bus: run permission, datapath/microcode inputs and
// the program-counter / microcode-ROM control and status outputs.
// The master side is the sequencer; the slave side is the surrounding
// datapath, microcode ROM and status logic.
interface execution_sequencer_if #(
   parameter int OPCODE_WIDTH = 8,
   parameter int UADDR_WIDTH  = 16,
   parameter int ICOUNT_WIDTH = 16
);
   // Inputs to the sequencer
   logic                    enable;
   logic [OPCODE_WIDTH-1:0] opcode;
   logic [UADDR_WIDTH-1:0]  entry_address;
   logic                    finish;
   logic                    jump_flag;

   // Outputs from the sequencer
   logic [UADDR_WIDTH-1:0]  uaddr;
   logic                    urom_read_enable;
   logic                    pc_enable;
   logic                    pc_load_n;
   logic                    halted;
   logic                    fault;
   logic [2:0]              state;
   logic [ICOUNT_WIDTH-1:0] instr_count;

   modport master (
      input  enable, opcode, entry_address, finish, jump_flag,
      output uaddr, urom_read_enable, pc_enable, pc_load_n,
             halted, fault, state, instr_count
   );

   modport slave (
      output enable, opcode, entry_address, finish, jump_flag,
      input  uaddr, urom_read_enable, pc_enable, pc_load_n,
             halted, fault, state, instr_count
   );
endinterface

// File: rtl/execution_sequencer.sv
// Execution sequencer: steps each instruction through
// FETCH -> DECODE -> EXECUTE -> RETIRE, drives the microcode ROM address and
// read enable, and pulses the program counter enable/load in RETIRE.
// Fetch wait-states, a sticky halt opcode, a runaway-microcode watchdog with
// sticky fault, and a retired-instruction counter are included.
// Every output is decoded from registered state only.
module execution_sequencer #(
   parameter int                      OPCODE_WIDTH      = 8,
   parameter int                      UADDR_WIDTH       = 16,
   parameter int                      FETCH_WAIT_CYCLES = 1,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE       = {OPCODE_WIDTH{1'b1}},
   parameter int                      MAX_USTEPS        = 64,
   parameter int                      ICOUNT_WIDTH      = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   execution_sequencer_if.master  io_seq
);

   // A wait-state count below one still spends one cycle in FETCH.
   localparam int FETCH_CYC = (FETCH_WAIT_CYCLES < 1) ? 1 : FETCH_WAIT_CYCLES;
   localparam int WAIT_W    = (FETCH_CYC > 1) ? $clog2(FETCH_CYC) : 1;
   localparam int STEP_W    = (MAX_USTEPS > 1) ? $clog2(MAX_USTEPS) : 1;

   // The wait counter counts down to zero; the step counter counts up to the limit.
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(FETCH_CYC - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_USTEPS - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_RETIRE  = 3'd4,
      ST_HALT    = 3'd5,
      ST_FAULT   = 3'd6
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [WAIT_W-1:0]       r_wait;
   logic [WAIT_W-1:0]       w_wait_nxt;
   logic [STEP_W-1:0]       r_step;
   logic [STEP_W-1:0]       w_step_nxt;
   logic [UADDR_WIDTH-1:0]  r_uaddr;
   logic [UADDR_WIDTH-1:0]  w_uaddr_nxt;
   logic                    r_jump;
   logic                    w_jump_nxt;
   logic [ICOUNT_WIDTH-1:0] r_icount;
   logic [ICOUNT_WIDTH-1:0] w_icount_nxt;

   // State register; reset parks the sequencer in IDLE immediately.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Counters, microcode address, captured jump and retired count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wait   <= '0;
         r_step   <= '0;
         r_uaddr  <= '0;
         r_jump   <= 1'b0;
         r_icount <= '0;
      end else begin
         r_wait   <= w_wait_nxt;
         r_step   <= w_step_nxt;
         r_uaddr  <= w_uaddr_nxt;
         r_jump   <= w_jump_nxt;
         r_icount <= w_icount_nxt;
      end
   end

   // Next-state and next-value decode; everything holds unless a state acts on it.
   always_comb begin
      w_state_nxt  = r_state;
      w_wait_nxt   = r_wait;
      w_step_nxt   = r_step;
      w_uaddr_nxt  = r_uaddr;
      w_jump_nxt   = r_jump;
      w_icount_nxt = r_icount;

      case (r_state)
         ST_IDLE: begin
            // enable only matters at instruction boundaries (here and RETIRE)
            if (io_seq.enable) begin
               w_state_nxt = ST_FETCH;
               w_wait_nxt  = WAIT_LOAD;
            end
         end

         ST_FETCH: begin
            if (r_wait == '0) begin
               w_state_nxt = ST_DECODE;
            end else begin
               w_wait_nxt = r_wait - 1'b1;
            end
         end

         ST_DECODE: begin
            if (io_seq.opcode == HALT_OPCODE) begin
               w_state_nxt = ST_HALT;
            end else begin
               w_state_nxt = ST_EXECUTE;
               w_uaddr_nxt = io_seq.entry_address;
               w_step_nxt  = '0;
            end
         end

         ST_EXECUTE: begin
            // finish wins over the watchdog limit in the same cycle
            if (io_seq.finish) begin
               w_state_nxt = ST_RETIRE;
               w_jump_nxt  = io_seq.jump_flag;
            end else if (r_step == STEP_LAST) begin
               w_state_nxt = ST_FAULT;
            end else begin
               w_uaddr_nxt = r_uaddr + 1'b1;
               w_step_nxt  = r_step + 1'b1;
            end
         end

         ST_RETIRE: begin
            w_icount_nxt = r_icount + 1'b1;
            if (io_seq.enable) begin
               w_state_nxt = ST_FETCH;
               w_wait_nxt  = WAIT_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_HALT,
         ST_FAULT: begin
            // terminal until reset
            w_state_nxt = r_state;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Moore output decode from registered state.
   always_comb begin
      io_seq.uaddr            = r_uaddr;
      io_seq.urom_read_enable = (r_state == ST_EXECUTE);
      io_seq.pc_enable        = (r_state == ST_RETIRE);
      io_seq.pc_load_n        = ~((r_state == ST_RETIRE) & r_jump);
      io_seq.halted           = (r_state == ST_HALT);
      io_seq.fault            = (r_state == ST_FAULT);
      io_seq.state            = r_state;
      io_seq.instr_count      = r_icount;
   end

endmodule
